// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-NOR flash target: read, status, JEDEC ID and power-down/wake, oversampled in clk.
// Define SPI_RESP_FAST_READ_EN to also accept 0x0B fast read (24 address bits + 8 dummy clocks).
module spi_flash_responder #(
  parameter int          MEM_AW       = 16,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4016,
  parameter logic [7:0]  STATUS_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic [7:0]        mem_rd_data,
  output logic              powered_down
);

`ifdef SPI_RESP_FAST_READ_EN
  localparam bit FAST_READ_EN = 1'b1;
`else
  localparam bit FAST_READ_EN = 1'b0;
`endif

  // Only the bits that can reach the command decoder or mem_addr are kept; higher address bits mirror.
  localparam int SHW = (MEM_AW - 1 > 7) ? MEM_AW - 1 : 7;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_FAST   = 8'h0B;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_JEDEC  = 8'h9F;
  localparam logic [7:0] CMD_PD     = 8'hB9;
  localparam logic [7:0] CMD_WAKE   = 8'hAB;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STATUS = 3'd5;
  localparam logic [2:0] S_JEDEC  = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  logic [1:0]     r_sck_sync, r_cs_sync, r_mosi_sync;
  logic           r_sck_d;
  logic [2:0]     r_state;
  logic [4:0]     r_bit_cnt;
  logic [SHW-1:0] r_shift;
  logic [7:0]     r_tx, r_pref;
  logic [2:0]     r_tx_cnt;
  logic [1:0]     r_id_idx;
  logic           r_fast, r_load, r_load_tx, r_pend_pd, r_pend_wake;

  logic       w_rise, w_fall, w_cs_high, w_mosi;
  logic [7:0] w_cmd;
  logic [7:0] w_next_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sck_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage read the previous stage's old value,
      // which is what turns these lines into a real 2-flop synchronizer chain.
      r_sck_sync  <= {r_sck_sync[0], spi_sck};
      r_cs_sync   <= {r_cs_sync[0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_sck_d     <= r_sck_sync[1];
    end
  end

  assign w_rise    = r_sck_sync[1] & ~r_sck_d;
  assign w_fall    = ~r_sck_sync[1] & r_sck_d;
  assign w_cs_high = r_cs_sync[1];
  assign w_mosi    = r_mosi_sync[1];
  assign w_cmd     = {r_shift[6:0], w_mosi};

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_next_byte = 8'h00;
    case (r_state)
      S_DATA:   w_next_byte = r_pref;
      S_STATUS: w_next_byte = STATUS_VALUE;
      S_JEDEC: begin
        case (r_id_idx)
          2'd1:    w_next_byte = JEDEC_ID[15:8];
          2'd2:    w_next_byte = JEDEC_ID[7:0];
          default: w_next_byte = 8'h00;
        endcase
      end
      default:  w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 5'd0;
      r_shift      <= '0;
      r_tx         <= 8'h00;
      r_pref       <= 8'h00;
      r_tx_cnt     <= 3'd0;
      r_id_idx     <= 2'd0;
      r_fast       <= 1'b0;
      r_load       <= 1'b0;
      r_load_tx    <= 1'b0;
      r_pend_pd    <= 1'b0;
      r_pend_wake  <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      mem_addr     <= '0;
      mem_rd_req   <= 1'b0;
      powered_down <= 1'b0;
    end else begin
      mem_rd_req <= 1'b0;
      // Read data is valid the cycle after the strobe; r_load marks that cycle.
      r_load     <= mem_rd_req;
      if (r_load) begin
        if (r_load_tx) r_tx   <= mem_rd_data;
        else           r_pref <= mem_rd_data;
      end

      if (w_cs_high) begin
        r_state     <= S_IDLE;
        spi_miso_oe <= 1'b0;
        r_bit_cnt   <= 5'd0;
        r_tx_cnt    <= 3'd0;
        if (r_pend_pd)        powered_down <= 1'b1;
        else if (r_pend_wake) powered_down <= 1'b0;
        r_pend_pd   <= 1'b0;
        r_pend_wake <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_CMD;
            r_bit_cnt <= 5'd0;
            r_tx_cnt  <= 3'd0;
          end
          S_CMD: if (w_rise) begin
            r_shift   <= {r_shift[SHW-2:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_IGNORE;
              if (!powered_down || w_cmd == CMD_WAKE) begin
                case (w_cmd)
                  CMD_READ: begin
                    r_state <= S_ADDR;
                    r_fast  <= 1'b0;
                  end
                  CMD_FAST: if (FAST_READ_EN) begin
                    r_state <= S_ADDR;
                    r_fast  <= 1'b1;
                  end
                  CMD_STATUS: begin
                    r_state <= S_STATUS;
                    r_tx    <= STATUS_VALUE;
                  end
                  CMD_JEDEC: begin
                    r_state  <= S_JEDEC;
                    r_tx     <= JEDEC_ID[23:16];
                    r_id_idx <= 2'd1;
                  end
                  CMD_PD:   r_pend_pd   <= 1'b1;
                  CMD_WAKE: r_pend_wake <= 1'b1;
                  default:  ;
                endcase
              end
            end
          end
          S_ADDR: if (w_rise) begin
            r_shift   <= {r_shift[SHW-2:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_bit_cnt  <= 5'd0;
              mem_addr   <= {r_shift[MEM_AW-2:0], w_mosi};
              mem_rd_req <= 1'b1;
              r_load_tx  <= 1'b1;
              r_state    <= r_fast ? S_DUMMY : S_DATA;
            end
          end
          S_DUMMY: if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_DATA;
            end
          end
          S_DATA, S_STATUS, S_JEDEC: if (w_fall) begin
            spi_miso_oe <= 1'b1;
            spi_miso    <= r_tx[7];
            r_tx        <= {r_tx[6:0], 1'b0};
            r_tx_cnt    <= r_tx_cnt + 3'd1;
            // Bit 7 going out: advance and prefetch so the next byte is ready 8 falls later.
            if (r_state == S_DATA && r_tx_cnt == 3'd0) begin
              mem_addr   <= mem_addr + MEM_AW'(1);
              mem_rd_req <= 1'b1;
              r_load_tx  <= 1'b0;
            end
            if (r_tx_cnt == 3'd7) begin
              r_tx <= w_next_byte;
              if (r_state == S_JEDEC && r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
            end
          end
          S_IGNORE: if (w_rise) begin
            // Power-down/wake only take effect after exactly 8 bits; any extra bit cancels them.
            r_pend_pd   <= 1'b0;
            r_pend_wake <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a mode-0 SPI master drives directed transactions,
// expected MISO bytes are queued at issue time and a monitor deserialises and compares them.
module tb_spi_flash_responder;
  localparam int MEM_AW = 16;
  localparam int HALF   = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_cs = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_req;
  logic [7:0]        mem_rd_data;
  logic              powered_down;

  always #5 clk = ~clk;

  spi_flash_responder #(.MEM_AW(MEM_AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sck      (spi_sck),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .mem_addr     (mem_addr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_data  (mem_rd_data),
    .powered_down (powered_down)
  );

  logic [7:0] mem [0:65535];
  always @(posedge clk) if (mem_rd_req) mem_rd_data <= mem[mem_addr];

  int n_checks = 0;
  int n_errors = 0;
  int req_cnt  = 0;
  int oe_cnt   = 0;
  always @(negedge clk) begin
    if (mem_rd_req)  req_cnt++;
    if (spi_miso_oe) oe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: stimulus pushes expected bytes, the monitor pops on every completed MISO byte.
  logic [7:0] exp_q[$];
  int         mon_bits = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;

  always @(posedge spi_sck or posedge spi_cs) begin
    if (spi_cs || !spi_miso_oe) begin
      mon_bits = 0;
    end else begin
      mon_byte = {mon_byte[6:0], spi_miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL miso_unexpected_byte: got %0h expected none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          check("miso_byte", 32'(mon_byte), 32'(mon_exp));
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    #HALF;
  endtask

  // CS rises while SCK is still high after the last rise, so the trailing fall is outside the frame.
  task automatic cs_high();
    spi_cs = 1'b1;
    #HALF;
    spi_sck = 1'b0;
    #(2 * HALF);
  endtask

  task automatic xfer(input logic [7:0] d, output logic oe_first);
    for (int i = 7; i >= 0; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = d[i];
      #HALF;
      if (i == 7) oe_first = spi_miso_oe;
      spi_sck = 1'b1;
      #HALF;
    end
  endtask

  task automatic send(input logic [7:0] d);
    logic oe_f;
    xfer(d, oe_f);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   req0;
    int   oe0;
    logic oe_f;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'(i) ^ 8'hA5;
    mem[16'hFFFF] = 8'h3C;
    mem[16'h0000] = 8'h5A;
    mem[16'h0001] = 8'hC3;

    idle(3);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_oe", 32'(spi_miso_oe), 0);
    check("rst_rd_req", 32'(mem_rd_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_powered_down", 32'(powered_down), 0);
    reset = 1'b1;
    idle(4);

    // JEDEC ID then zero fill
    cs_low();
    send(8'h9F);
    check("jedec_oe_before_8th_fall", 32'(spi_miso_oe), 0);
    push(8'hEF); push(8'h40); push(8'h16); push(8'h00); push(8'h00);
    xfer(8'h00, oe_f);
    check("jedec_oe_after_8th_fall", 32'(oe_f), 1);
    for (int i = 0; i < 4; i++) send(8'h00);
    spi_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("jedec_oe_off_3clk", 32'(spi_miso_oe), 0);
    #HALF;
    spi_sck = 1'b0;
    idle(10);

    // Plain read of 4 bytes at 0x000100
    req0 = req_cnt;
    cs_low();
    send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    push(8'hA5); push(8'hA4); push(8'hA7); push(8'hA6);
    for (int i = 0; i < 4; i++) send(8'h00);
    cs_high();
    check("read_rd_req_count", 32'(req_cnt - req0), 5);

    // Address wrap; the high address byte is ignored
    cs_low();
    send(8'h03); send(8'h01); send(8'hFF); send(8'hFF);
    push(8'h3C); push(8'h5A); push(8'hC3);
    for (int i = 0; i < 3; i++) send(8'h00);
    cs_high();

    // Aborted read, then unknown command
    req0 = req_cnt;
    oe0  = oe_cnt;
    cs_low();
    send(8'h03); send(8'h12);
    cs_high();
    cs_low();
    send(8'h42); send(8'h00); send(8'h00);
    cs_high();
    check("abort_no_rd_req", 32'(req_cnt - req0), 0);
    check("abort_oe_stays_0", 32'(oe_cnt - oe0), 0);
    cs_low();
    send(8'h05);
    push(8'h00);
    send(8'hFF);
    cs_high();

    // Power-down blocks JEDEC, wake restores it
    cs_low();
    send(8'hB9);
    cs_high();
    check("pd_asserted", 32'(powered_down), 1);
    oe0 = oe_cnt;
    cs_low();
    send(8'h9F); send(8'h00); send(8'h00); send(8'h00);
    cs_high();
    check("pd_jedec_oe_stays_0", 32'(oe_cnt - oe0), 0);
    cs_low();
    send(8'hAB);
    cs_high();
    check("pd_released", 32'(powered_down), 0);
    cs_low();
    send(8'h9F);
    push(8'hEF); push(8'h40); push(8'h16);
    for (int i = 0; i < 3; i++) send(8'h00);
    cs_high();

    // Reset during the second data byte
    cs_low();
    send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    push(8'hA5);
    send(8'h00);
    for (int i = 0; i < 3; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      #HALF;
      spi_sck = 1'b1;
      #HALF;
    end
    reset = 1'b0;
    #1;
    check("midrst_miso", 32'(spi_miso), 0);
    check("midrst_oe", 32'(spi_miso_oe), 0);
    check("midrst_rd_req", 32'(mem_rd_req), 0);
    check("midrst_mem_addr", 32'(mem_addr), 0);
    check("midrst_powered_down", 32'(powered_down), 0);
    spi_cs  = 1'b1;
    spi_sck = 1'b0;
    idle(4);
    reset = 1'b1;
    idle(4);
    cs_low();
    cs_high();
    cs_low();
    send(8'h03); send(8'h00); send(8'h01); send(8'h02);
    push(8'hA7); push(8'hA6);
    send(8'h00); send(8'h00);
    cs_high();

`ifdef SPI_RESP_FAST_READ_EN
    cs_low();
    send(8'h0B); send(8'h00); send(8'h01); send(8'h00);
    send(8'h00);
    push(8'hA5); push(8'hA4);
    send(8'h00); send(8'h00);
    cs_high();
`endif

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
SPI flash target (responder) emulating the subset of a serial NOR flash the bootloader's SPI master issues: read, status, JEDEC ID and power-down/wake. It oversamples SCK/CS/MOSI in the system clock domain and serves read data from a synchronous byte memory (iCE40 BRAM). It is used as a bench/loopback target for the bootloader's flash path, and on boards that expose the fabric as a flash-like device to another host.

Parameters:
MEM_AW, 16, byte-address width of backing memory; flash address bits above MEM_AW-1 are ignored (mirror).
JEDEC_ID, 24'hEF4016, three ID bytes returned MSB first for 0x9F.
STATUS_VALUE, 8'h00, byte returned for 0x05 (bit0 WIP is always 0).

Ports:
clk  input  1  system clock; must be >= 8x SCK frequency.
reset  input  1  asynchronous, active-low reset.
spi_sck  input  1  SPI clock from master, mode 0, asynchronous to clk.
spi_cs  input  1  chip select, active-low, asynchronous.
spi_mosi  input  1  master-out data.
spi_miso  output  1  target-out data, MSB first.
spi_miso_oe  output  1  1 = drive spi_miso pad; feeds tristate SB_IO enable.
mem_addr  output  MEM_AW  byte read address.
mem_rd_req  output  1  one-cycle read strobe.
mem_rd_data  input  8  read data, valid exactly 1 clk after mem_rd_req.
powered_down  output  1  1 after 0xB9 until 0xAB.

Behaviour:
- Reset (reset=0): spi_miso=0, spi_miso_oe=0, mem_rd_req=0, mem_addr=0, powered_down=0, FSM=IDLE; immediate, no clock needed.
- Inputs pass 2-flop synchronizers; sck_rise/sck_fall are 1-clk pulses from the synchronized SCK. MOSI is sampled on sck_rise. MISO is updated on sck_fall, at most 4 clk after the pad edge.
- Synchronized CS high forces IDLE in the same cycle, from any state. It also sets spi_miso_oe=0, clears the bit counter and discards any partial byte. A command executes only on completion of its required bytes. 0xB9/0xAB take effect on the CS rising edge after exactly 8 bits.
- FSM: IDLE -(CS low)-> CMD.
  - CMD: after the 8th rise, decode:
    - 0x03 -> ADDR
    - 0x05 -> STATUS
    - 0x9F -> JEDEC
    - 0xB9/0xAB -> IGNORE (latched as pending)
    - any other -> IGNORE.
  - powered_down=1: every command except 0xAB decodes to IGNORE.
  - ADDR: shift 24 bits MSB first. On the 24th rise, mem_addr<=addr[MEM_AW-1:0] and mem_rd_req pulses; the byte is captured into the shift register 1 clk later -> DATA.
  - DATA: spi_miso_oe=1 from the first sck_fall after the address. Bit 7 is driven on that fall, bits 6..0 on the following falls. When bit 7 of a byte is driven, mem_addr increments (wraps 2^MEM_AW-1 -> 0) and the next byte is prefetched. Streaming continues until CS high.
  - STATUS: drive STATUS_VALUE repeatedly until CS high.
  - JEDEC: drive JEDEC_ID[23:16], [15:8], [7:0], then 0x00 repeatedly.
  - IGNORE: spi_miso_oe=0, consume bits until CS high.
- SCK edges while CS high are ignored. A CS low pulse with no SCK edges returns to IDLE without side effects.
- spi_miso holds its last value when oe=0; the value is don't-care for verification.

Optional Feature:
SPI_RESP_FAST_READ_EN:
- Defined: command 0x0B accepted. After 24 address bits it consumes 8 dummy clocks (MISO tristated), then streams data exactly like 0x03. The prefetch is issued on the 24th address rise.
- Undefined: 0x0B decodes to IGNORE.

Test Plan:
- JEDEC: CS low, send 0x9F, clock 40 more bits -> MISO bytes EF 40 16 00 00; oe=1 only after 8th fall; oe=0 within 3 clk of CS high.
- Read: mem[0x0100+i]=i^0xA5; send 03 00 01 00, clock 4 bytes -> A5 A4 A7 A6; mem_rd_req pulses 5 times (4 served + 1 prefetch).
- Wrap: MEM_AW=16, read at 0x01FFFF -> returns mem[0xFFFF], mem[0x0000], mem[0x0001]; the high address byte is ignored.
- Abort/unknown: send 03 12 then CS high, then 0x42 + 16 clocks -> no mem_rd_req, oe stays 0; a following 05 + 8 clocks returns 0x00.
- Power-down: B9, CS high; 9F + 24 clocks -> oe stays 0; AB, CS high -> powered_down=0; 9F returns EF 40 16.
- Reset mid-read: reset=0 during the 2nd data byte -> outputs at reset values immediately. After release and CS cycle, a fresh 03 read returns correct data. With SPI_RESP_FAST_READ_EN, 0B 00 01 00 + 8 dummy -> A5 A4.
